// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : uart_tx_arbiter                                                    |
// | Desc   : Round-robin sharing of one uart_tx between two buffered producers. |
// |          Optional tx_par output is enabled by macro UART_TXARB_PARITY_EN.   |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+

module uart_tx_arbiter_fifo #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] din,
  input  logic            pop,
  output logic [DBIT-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic            ovf
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  logic [DBIT-1:0]    mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               w_wr_ok;
  logic               w_pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = mem_q[rptr_q];
  assign ovf   = ovf_q;

  // Fullness is judged on the registered count, so a pop never makes room
  // for a write landing in the same cycle.
  always_comb begin
    w_wr_ok  = wr & ~full;
    w_pop_ok = pop & ~empty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = wr & full;
    if (w_wr_ok)  wptr_d = wptr_q + 1'b1;
    if (w_pop_ok) rptr_d = rptr_q + 1'b1;
    case ({w_wr_ok, w_pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (w_wr_ok) mem_q[wptr_q] <= din;
    end
  end
endmodule

module uart_tx_arbiter #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_wr,
  input  logic [DBIT-1:0] a_din,
  output logic            a_full,
  output logic            a_ovf,
  input  logic            b_wr,
  input  logic [DBIT-1:0] b_din,
  output logic            b_full,
  output logic            b_ovf,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick,
  output logic            busy,
`ifdef UART_TXARB_PARITY_EN
  output logic            tx_par,
`endif
  output logic            src
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            src_q, src_d;
  logic            rr_q, rr_d;
`ifdef UART_TXARB_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            a_pop, b_pop;
  logic            a_empty, b_empty;
  logic [DBIT-1:0] a_dout, b_dout;
  logic            w_grant_b;

  uart_tx_arbiter_fifo #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .wr    (a_wr),
    .din   (a_din),
    .pop   (a_pop),
    .dout  (a_dout),
    .empty (a_empty),
    .full  (a_full),
    .ovf   (a_ovf)
  );

  uart_tx_arbiter_fifo #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .wr    (b_wr),
    .din   (b_din),
    .pop   (b_pop),
    .dout  (b_dout),
    .empty (b_empty),
    .full  (b_full),
    .ovf   (b_ovf)
  );

  // rr_q names the port preferred on a tie (0=A, 1=B); it only moves on frame completion.
  always_comb begin
    state_d    = state_q;
    tx_din_d   = tx_din_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    src_d      = src_q;
    rr_d       = rr_q;
    a_pop      = 1'b0;
    b_pop      = 1'b0;
    w_grant_b  = 1'b0;
`ifdef UART_TXARB_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!a_empty || !b_empty) begin
          w_grant_b  = a_empty | (~b_empty & rr_q);
          tx_din_d   = w_grant_b ? b_dout : a_dout;
          src_d      = w_grant_b;
          a_pop      = ~w_grant_b;
          b_pop      = w_grant_b;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_START;
`ifdef UART_TXARB_PARITY_EN
          par_d      = ^(w_grant_b ? b_dout : a_dout);
`endif
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (tx_done_tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          rr_d    = ~src_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_din_q   <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      src_q      <= 1'b0;
      rr_q       <= 1'b0;
`ifdef UART_TXARB_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_din_q   <= tx_din_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      src_q      <= src_d;
      rr_q       <= rr_d;
`ifdef UART_TXARB_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = busy_q;
  assign src      = src_q;
`ifdef UART_TXARB_PARITY_EN
  assign tx_par   = par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_uart_tx_arbiter                                                 |
// | Desc   : Directed + random bench with a queue-based reference model.        |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_wr = 1'b0, b_wr = 1'b0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_full, a_ovf, b_full, b_ovf;
  logic       tx_start, busy, src;
  logic [7:0] tx_din;
  logic       tx_done_tick = 1'b0;
`ifdef UART_TXARB_PARITY_EN
  logic       tx_par;
`endif

  uart_tx_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_wr         (a_wr),
    .a_din        (a_din),
    .a_full       (a_full),
    .a_ovf        (a_ovf),
    .b_wr         (b_wr),
    .b_din        (b_din),
    .b_full       (b_full),
    .b_ovf        (b_ovf),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
`ifdef UART_TXARB_PARITY_EN
    .tx_par       (tx_par),
`endif
    .src          (src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         wc;
  } ent_t;

  // Reference model: byte queues stamped with their write cycle, plus frame bookkeeping.
  ent_t       qa[$], qb[$];
  logic [7:0] log_q[$];
  int         cyc = 0;
  int         start_cyc = 0, done_cyc = 0, dly = 3;
  bit         in_frame = 0, last = 1, hold = 0, spur = 0, rand_dly = 0;
  logic [7:0] exp_din = '0;
  logic       exp_src = 0, exp_start = 0, exp_busy = 0, exp_aovf = 0, exp_bovf = 0;
  int         total = 0, bad = 0, ovf_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    in_frame = 0; last = 1; exp_din = '0; exp_src = 0;
    exp_start = 0; exp_busy = 0; exp_aovf = 0; exp_bovf = 0;
  endtask

  task automatic cycle(input logic aw, input logic [7:0] ad, input logic bw, input logic [7:0] bd);
    logic fa, fb, av, bv, pb, in_busy, d;
    ent_t e;
    a_wr = aw; a_din = ad; b_wr = bw; b_din = bd;
    fa = (qa.size() == DEPTH);
    fb = (qb.size() == DEPTH);
    in_busy = in_frame && (cyc > start_cyc);
    d = 1'b0;
    if (in_busy) d = !hold && (cyc >= done_cyc);
    else if (spur) d = ($urandom_range(0, 3) == 0);
    tx_done_tick = d;
    av = 0; bv = 0;
    if (qa.size() > 0) av = (qa[0].wc < cyc);
    if (qb.size() > 0) bv = (qb[0].wc < cyc);
    exp_start = 0;
    if (!in_frame && (av || bv)) begin
      pb = (av && bv) ? ~last : bv;
      if (pb) e = qb.pop_front(); else e = qa.pop_front();
      exp_din = e.d; exp_src = pb; exp_start = 1; in_frame = 1;
      start_cyc = cyc + 1;
      done_cyc = start_cyc + (rand_dly ? int'($urandom_range(1, 6)) : dly);
    end else if (in_busy && d) begin
      in_frame = 0; last = exp_src;
    end
    exp_busy = in_frame;
    exp_aovf = aw && fa;
    exp_bovf = bw && fb;
    if (aw && !fa) begin e.d = ad; e.wc = cyc; qa.push_back(e); end
    if (bw && !fb) begin e.d = bd; e.wc = cyc; qb.push_back(e); end
    @(posedge clk); #1; cyc++;
    if (tx_start === 1'b1) log_q.push_back(tx_din);
    if (b_ovf === 1'b1) ovf_seen++;
    chk("tx_start", tx_start, exp_start);
    chk("busy", busy, exp_busy);
    chk("tx_din", tx_din, exp_din);
    chk("src", src, exp_src);
    chk("a_full", a_full, qa.size() == DEPTH);
    chk("b_full", b_full, qb.size() == DEPTH);
    chk("a_ovf", a_ovf, exp_aovf);
    chk("b_ovf", b_ovf, exp_bovf);
`ifdef UART_TXARB_PARITY_EN
    chk("tx_par", tx_par, ^exp_din);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 8'h00, 0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_din"}, tx_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_src"}, src, 0);
    chk({tag, "_full"}, {a_full, b_full}, 0);
    chk({tag, "_ovf"}, {a_ovf, b_ovf}, 0);
`ifdef UART_TXARB_PARITY_EN
    chk({tag, "_par"}, tx_par, 0);
`endif
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst");
    model_reset();
    hold = 0;
    tx_done_tick = 0; a_wr = 0; b_wr = 0;
    @(posedge clk); #1; cyc++;
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single byte, 20-cycle frame
    dly = 20; log_q.delete();
    cycle(1, 8'hB5, 0, 8'h00);
    idle(26);
    chk("single_cnt", log_q.size(), 1);
    if (log_q.size() > 0) chk("single_byte", log_q[0], 8'hB5);

    // Fairness from a fresh reset
    do_reset();
    dly = 3; log_q.delete();
    cycle(1, 8'h11, 1, 8'h33);
    cycle(1, 8'h22, 1, 8'h44);
    idle(30);
    chk("fair_cnt", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("fair_0", log_q[0], 8'h11);
      chk("fair_1", log_q[1], 8'h33);
      chk("fair_2", log_q[2], 8'h22);
      chk("fair_3", log_q[3], 8'h44);
    end

    // Overflow on B while arbiter held busy
    log_q.delete(); hold = 1;
    cycle(1, 8'h99, 0, 8'h00);
    idle(3);
    ovf_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 8'h00, 1, 8'(i));
      if (i == 4) chk("b_full_after4", b_full, 1);
    end
    hold = 0;
    idle(40);
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_cnt", log_q.size(), 5);
    if (log_q.size() == 5)
      for (int i = 1; i < 5; i++) chk("ovf_byte", log_q[i], i);

    // Pop and write to A in the same cycle
    log_q.delete();
    cycle(1, 8'h5A, 0, 8'h00);
    cycle(1, 8'h6B, 0, 8'h00);
    idle(20);
    chk("simul_cnt", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("simul_0", log_q[0], 8'h5A);
      chk("simul_1", log_q[1], 8'h6B);
    end

    // Parity pair
    log_q.delete();
    cycle(1, 8'hE7, 0, 8'h00);
    idle(3);
`ifdef UART_TXARB_PARITY_EN
    chk("par_e7", tx_par, 0);
`endif
    idle(8);
    cycle(1, 8'hE3, 0, 8'h00);
    idle(3);
`ifdef UART_TXARB_PARITY_EN
    chk("par_e3", tx_par, 1);
`endif
    idle(8);
    chk("par_cnt", log_q.size(), 2);

    // Random traffic with varying write pressure and stray done ticks
    spur = 1; rand_dly = 1;
    for (int i = 0; i < 800; i++) begin
      int rate;
      rate = (i < 300) ? 15 : ((i < 550) ? 60 : 30);
      cycle($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 99) < rate, 8'($urandom));
    end
    spur = 0; rand_dly = 0;
    idle(40);

    // Reset while busy with three bytes queued
    hold = 1;
    cycle(1, 8'h71, 0, 8'h00);
    idle(3);
    cycle(1, 8'h72, 1, 8'h81);
    cycle(1, 8'h73, 0, 8'h00);
    chk("pre_rst_busy", busy, 1);
    do_reset();
    log_q.delete();
    idle(12);
    chk("post_rst_quiet", log_q.size(), 0);
    cycle(0, 8'h00, 1, 8'h5C);
    idle(10);
    chk("post_rst_cnt", log_q.size(), 1);
    if (log_q.size() == 1) chk("post_rst_byte", log_q[0], 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
